// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES segments of
// C = N/STAGES bits, with one global advance enable providing valid/ready backpressure.
module pipelined_addsub #(
  parameter int N      = 24,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int C = N / STAGES;
  localparam int L = STAGES - 1;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_param_check
    $error("pipelined_addsub: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  logic         en_s;
  logic [N-1:0] bc_s;
  logic         ovf_d;
  logic         zero_d;
  logic         ovf_q;
  logic         zero_q;

  // The whole pipeline moves together; it only freezes when a finished result is refused.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s && !rst;
  assign bc_s     = b ^ {N{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic                 v_in_s;
    logic [C-1:0]         op_a_s;
    logic [C-1:0]         op_b_s;
    logic                 cin_s;
    logic [C:0]           sum_s;
    logic [(k+1)*C-1:0]   res_d;
    logic [(k+1)*C-1:0]   res_q;
    logic                 v_q;
    logic                 cy_q;

    if (k == 0) begin : g_head
      assign v_in_s = in_valid && in_ready;
      assign op_a_s = a[C-1:0];
      assign op_b_s = bc_s[C-1:0];
      assign cin_s  = sub;
      assign res_d  = sum_s[C-1:0];
    end else begin : g_body
      assign v_in_s = g_st[k-1].v_q;
      assign op_a_s = g_st[k-1].g_skew.a_sk_q[C-1:0];
      assign op_b_s = g_st[k-1].g_skew.b_sk_q[C-1:0];
      assign cin_s  = g_st[k-1].cy_q;
      assign res_d  = {sum_s[C-1:0], g_st[k-1].res_q};
    end

    assign sum_s = {1'b0, op_a_s} + {1'b0, op_b_s} + {{C{1'b0}}, cin_s};

    // Skew registers carry only the operand bits not yet consumed; the bottom C bits feed the next segment.
    if (k < STAGES - 1) begin : g_skew
      localparam int RW = N - (k + 1) * C;
      logic [RW-1:0] a_sk_d;
      logic [RW-1:0] b_sk_d;
      logic [RW-1:0] a_sk_q;
      logic [RW-1:0] b_sk_q;

      if (k == 0) begin : g_src_in
        assign a_sk_d = a[N-1:C];
        assign b_sk_d = bc_s[N-1:C];
      end else begin : g_src_prev
        assign a_sk_d = g_st[k-1].g_skew.a_sk_q[RW+C-1:C];
        assign b_sk_d = g_st[k-1].g_skew.b_sk_q[RW+C-1:C];
      end

      // Operand skew register for the upper, still-pending segments.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (en_s && v_in_s) begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end
    end

    // Segment register: valid shifts with en even for bubbles, data only loads on a valid entry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        res_q <= '0;
        cy_q  <= 1'b0;
      end else if (en_s) begin
        v_q <= v_in_s;
        if (v_in_s) begin
          res_q <= res_d;
          cy_q  <= sum_s[C];
        end
      end
    end
  end

  // The top segment sees the sign bits of A and conditioned B as its operand MSBs.
  assign ovf_d  = (g_st[L].op_a_s[C-1] == g_st[L].op_b_s[C-1]) &&
                  (g_st[L].sum_s[C-1] != g_st[L].op_a_s[C-1]);
  assign zero_d = (g_st[L].res_d == '0);

  // Status flags registered together with the final result segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en_s && g_st[L].v_in_s) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = g_st[L].v_q;
  assign s         = g_st[L].res_q;
  assign c_out     = g_st[L].cy_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
